// File: rtl/buffered_mem_write.sv
// Buffered random-access memory writer: a DEPTH-entry request FIFO drained into a
// single-outstanding write port, with optional flag-based skipping and saturating statistics.
module buffered_mem_write #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int COND_WRITE = 0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [COND_WRITE+ADDR_WIDTH+DATA_WIDTH-1:0]   data_i,
    input  logic                                          valid_i,
    output logic                                          ready_o,
    output logic                                          mem_write,
    output logic [ADDR_WIDTH-1:0]                         mem_addr,
    output logic [DATA_WIDTH-1:0]                         mem_wdata,
    input  logic                                          mem_resp,
    output logic                                          done,
    output logic [$clog2(DEPTH):0]                        occupancy,
    output logic [CNT_WIDTH-1:0]                          write_count,
    output logic [CNT_WIDTH-1:0]                          skip_count
);

    localparam int IN_WIDTH = COND_WRITE + ADDR_WIDTH + DATA_WIDTH;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int OCC_W    = PTR_W + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);

    // Head is read asynchronously so an entry can be popped the cycle after it lands.
    logic [IN_WIDTH-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [OCC_W-1:0]      count_reg;
    logic [OCC_W-1:0]      count_next;
    logic [0:0]            state_reg;
    logic [0:0]            state_next;
    logic                  mem_write_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic [CNT_WIDTH-1:0]  write_count_reg;
    logic [CNT_WIDTH-1:0]  skip_count_reg;

    logic [IN_WIDTH-1:0]   head_entry;
    logic                  head_write;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  skip;
    logic                  resp_ok;

    assign head_entry = fifo_mem[rd_ptr_reg];

    generate
        if (COND_WRITE != 0) begin : g_cond
            assign head_write = head_entry[IN_WIDTH-1];
        end else begin : g_uncond
            assign head_write = 1'b1;
        end
    endgenerate

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == OCC_FULL);

    // No full-bypass: a pop in the same cycle does not reopen a full FIFO.
    assign ready_o = ~fifo_full;
    assign push    = valid_i & ~fifo_full;
    assign pop     = (state_reg == IDLE) & ~fifo_empty;
    assign issue   = pop & head_write;
    assign skip    = pop & ~head_write;
    assign resp_ok = (state_reg == ISSUE) & mem_resp;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (issue)   state_next = ISSUE;
            ISSUE:   if (resp_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            state_reg       <= IDLE;
            mem_write_reg   <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            write_count_reg <= '0;
            skip_count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (issue) begin
                mem_write_reg <= 1'b1;
                mem_addr_reg  <= head_entry[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
                mem_wdata_reg <= head_entry[DATA_WIDTH-1:0];
            end else if (resp_ok) begin
                mem_write_reg <= 1'b0;
            end
            if (resp_ok && write_count_reg != CNT_MAX) begin
                write_count_reg <= write_count_reg + 1'b1;
            end
            if (skip && skip_count_reg != CNT_MAX) begin
                skip_count_reg <= skip_count_reg + 1'b1;
            end
        end
    end

    assign mem_write   = mem_write_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign occupancy   = count_reg;
    assign done        = fifo_empty & (state_reg == IDLE);
    assign write_count = write_count_reg;
    assign skip_count  = skip_count_reg;

endmodule

// File: tb/tb_buffered_mem_write.sv
// Bench for buffered_mem_write: an unconditional instance with 2-bit counters and a
// conditional-write instance, checked against hand-computed tables and sequences.
module tb_buffered_mem_write;

    logic clk;
    logic rst;

    // Instance A: COND_WRITE = 0, CNT_WIDTH = 2
    logic [31:0] data_a;
    logic        valid_a, ready_a, mw_a, resp_a, resp_a_drv, tie_a, done_a;
    logic [15:0] ma_a, md_a;
    logic [2:0]  occ_a;
    logic [1:0]  wc_a, sc_a;

    // Instance B: COND_WRITE = 1, CNT_WIDTH = 8
    logic [32:0] data_b;
    logic        valid_b, ready_b, mw_b, resp_b, done_b;
    logic [15:0] ma_b, md_b;
    logic [2:0]  occ_b;
    logic [7:0]  wc_b, sc_b;

    assign resp_a = tie_a ? mw_a : resp_a_drv;
    assign resp_b = mw_b;

    buffered_mem_write #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4), .COND_WRITE(0), .CNT_WIDTH(2)) dut_a (
        .clk(clk), .rst(rst), .data_i(data_a), .valid_i(valid_a), .ready_o(ready_a),
        .mem_write(mw_a), .mem_addr(ma_a), .mem_wdata(md_a), .mem_resp(resp_a),
        .done(done_a), .occupancy(occ_a), .write_count(wc_a), .skip_count(sc_a)
    );

    buffered_mem_write #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4), .COND_WRITE(1), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .data_i(data_b), .valid_i(valid_b), .ready_o(ready_b),
        .mem_write(mw_b), .mem_addr(ma_b), .mem_wdata(md_b), .mem_resp(resp_b),
        .done(done_b), .occupancy(occ_b), .write_count(wc_b), .skip_count(sc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flag;
        logic [15:0] addr;
        logic [15:0] data;
        logic        expect_write;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] log_a[$];
    int          t_a[$];
    logic [31:0] log_b[$];

    logic [31:0] ent_a[8];
    logic [32:0] ent_b[4];

    // Completed writes, as seen on the memory port
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && mw_a && resp_a) begin
            log_a.push_back({ma_a, md_a});
            t_a.push_back(cyc);
        end
        if (!rst && mw_b && resp_b) begin
            log_b.push_back({ma_b, md_b});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input int n, input int max_cyc, output int acc);
        logic go;
        acc = 0;
        for (int c = 0; c < max_cyc && acc < n; c++) begin
            data_a  = ent_a[acc];
            valid_a = 1'b1;
            go      = ready_a;
            tick();
            if (go) acc++;
        end
        valid_a = 1'b0;
    endtask

    task automatic push_b(input int n, input int max_cyc, output int acc);
        logic go;
        acc = 0;
        for (int c = 0; c < max_cyc && acc < n; c++) begin
            data_b  = ent_b[acc];
            valid_b = 1'b1;
            go      = ready_b;
            tick();
            if (go) acc++;
        end
        valid_b = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t tab_b[4];
        vec_t tab_i[8];
        logic [31:0] exp_b[$];
        int acc;
        int nlog;

        tab_b[0] = '{1'b1, 16'h0000, 16'h1111, 1'b1};
        tab_b[1] = '{1'b0, 16'h0008, 16'h2222, 1'b0};
        tab_b[2] = '{1'b0, 16'h0010, 16'h3333, 1'b0};
        tab_b[3] = '{1'b1, 16'h0018, 16'h4444, 1'b1};
        for (int i = 0; i < 8; i++) begin
            tab_i[i] = '{1'b1, 16'h0200 + 16'(i * 4), 16'hC000 + 16'(i), 1'b1};
        end

        rst = 1'b1; valid_a = 0; valid_b = 0; data_a = '0; data_b = '0;
        resp_a_drv = 0; tie_a = 0;

        // Reset state
        do_reset();
        check("rst_occ", occ_a, 0);
        check("rst_ready", ready_a, 1);
        check("rst_done", done_a, 1);
        check("rst_mw", mw_a, 0);
        check("rst_addr", ma_a, 0);
        check("rst_wc", wc_a, 0);
        check("rst_sc", sc_b, 0);

        // Single write, response after 3 cycles of mem_write
        ent_a[0] = {16'h0010, 16'h00AA};
        push_a(1, 4, acc);
        check("single_acc", acc, 1);
        check("single_occ", occ_a, 1);
        check("single_done_fall", done_a, 0);
        check("single_mw_pre", mw_a, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("single_mw_hi", mw_a, 1);
            check("single_addr", ma_a, 16'h0010);
            check("single_data", md_a, 16'h00AA);
            if (i == 2) resp_a_drv = 1'b1;
            tick();
        end
        resp_a_drv = 1'b0;
        check("single_mw_lo", mw_a, 0);
        check("single_wc", wc_a, 1);
        check("single_done", done_a, 1);

        // Fill and backpressure, then drain; write_count saturates at 3
        do_reset();
        log_a.delete();
        for (int i = 0; i < 6; i++) ent_a[i] = {16'h0100 + 16'(i * 8), 16'hB000 + 16'(i)};
        push_a(6, 8, acc);
        check("fill_accepted", acc, 5);
        check("fill_occ", occ_a, 4);
        check("fill_ready", ready_a, 0);
        check("fill_mw", mw_a, 1);
        check("fill_addr", ma_a, 16'h0100);
        resp_a_drv = 1'b1;
        repeat (20) tick();
        resp_a_drv = 1'b0;
        check("fill_nwrites", log_a.size(), 5);
        for (int i = 0; i < 5 && i < log_a.size(); i++) check("fill_order", log_a[i], ent_a[i]);
        check("fill_done", done_a, 1);
        check("sat_wc", wc_a, 3);

        // Immediate response: 8 back-to-back entries, pointer wrap
        do_reset();
        log_a.delete();
        t_a.delete();
        tie_a = 1'b1;
        for (int i = 0; i < 8; i++) ent_a[i] = {tab_i[i].addr, tab_i[i].data};
        push_a(8, 40, acc);
        check("imm_accepted", acc, 8);
        repeat (30) tick();
        check("imm_nwrites", log_a.size(), 8);
        for (int i = 0; i < 8 && i < log_a.size(); i++) begin
            check("imm_order", log_a[i], {tab_i[i].addr, tab_i[i].data});
            if (i > 0) check("imm_spacing", t_a[i] - t_a[i-1], 2);
        end
        check("imm_done", done_a, 1);
        check("imm_wc_sat", wc_a, 3);

        // Reset mid-write with 3 entries buffered; late response ignored
        tie_a = 1'b0;
        push_a(4, 10, acc);
        check("midrst_acc", acc, 4);
        check("midrst_mw_pre", mw_a, 1);
        check("midrst_occ_pre", occ_a, 3);
        nlog = log_a.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_mw", mw_a, 0);
        check("midrst_occ", occ_a, 0);
        check("midrst_wc", wc_a, 0);
        check("midrst_done", done_a, 1);
        check("midrst_ready", ready_a, 1);
        resp_a_drv = 1'b1;
        tick();
        resp_a_drv = 1'b0;
        tick();
        check("late_resp_wc", wc_a, 0);
        check("late_resp_mw", mw_a, 0);
        check("late_resp_log", log_a.size(), nlog);

        // Conditional skip on instance B
        log_b.delete();
        for (int i = 0; i < 4; i++) begin
            ent_b[i] = {tab_b[i].flag, tab_b[i].addr, tab_b[i].data};
            if (tab_b[i].expect_write) exp_b.push_back({tab_b[i].addr, tab_b[i].data});
        end
        push_b(4, 12, acc);
        check("cond_accepted", acc, 4);
        repeat (12) tick();
        check("cond_nwrites", log_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < log_b.size(); i++) check("cond_order", log_b[i], exp_b[i]);
        check("cond_sc", sc_b, 2);
        check("cond_wc", wc_b, 2);
        check("cond_done", done_b, 1);
        check("cond_occ", occ_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buffered_mem_write.md
Name: buffered_mem_write

Overview:
Buffered, parametrised random-access memory writer for the graph-processing pipeline. It accepts {flag, addr, data} write requests from the upstream stage through a valid/ready handshake and stores them in a DEPTH-entry FIFO, so upstream is not stalled for the full memory round trip. It drains the FIFO into a single-outstanding-request memory port. In conditional mode it drops entries whose update flag is clear without touching memory. It reports drain completion and write/skip statistics to the controller.

Parameters:
ADDR_WIDTH, 64, memory address width
DATA_WIDTH, 64, memory write data width
DEPTH, 4, FIFO entries; power of two, >= 2
COND_WRITE, 0, 1 = data_i MSB is the update flag and entries with flag 0 are skipped; 0 = every entry is written
CNT_WIDTH, 32, width of the statistics counters
(derived) IN_WIDTH = COND_WRITE + ADDR_WIDTH + DATA_WIDTH

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
data_i  input  IN_WIDTH  {[flag], addr, data}; addr is bits [ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH], data is bits [DATA_WIDTH-1:0]
valid_i  input  1  upstream request valid
ready_o  output  1  FIFO can accept an entry
mem_write  output  1  memory write strobe, held until mem_resp
mem_addr  output  ADDR_WIDTH  write address, registered
mem_wdata  output  DATA_WIDTH  write data, registered
mem_resp  input  1  memory write acknowledge
done  output  1  FIFO empty and no write in flight
occupancy  output  $clog2(DEPTH)+1  current FIFO entry count
write_count  output  CNT_WIDTH  completed memory writes
skip_count  output  CNT_WIDTH  entries dropped due to flag = 0

Behaviour:
- Reset, synchronous on the clk edge while rst = 1, overrides everything:
  - FIFO emptied and pointers cleared; occupancy = 0; ready_o = 1; done = 1.
  - mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - write_count = 0, skip_count = 0; FSM returns to IDLE.
  - A write in flight is abandoned. A mem_resp arriving after reset is ignored.
- Push: occurs when valid_i & ready_o.
  - ready_o = (occupancy != DEPTH), derived from registered state only.
  - No full-bypass: when full, ready_o = 0 even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave occupancy unchanged.
  - The FIFO read and write pointers wrap modulo DEPTH.
- FSM states: IDLE and ISSUE.
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, head entry written (COND_WRITE = 0, or flag = 1): pop the head, load mem_addr and mem_wdata from it, set mem_write = 1, go to ISSUE.
  - IDLE, head entry skipped (COND_WRITE = 1 and flag = 0): pop the head, skip_count += 1, stay in IDLE. At most one pop per cycle.
  - ISSUE: hold mem_write, mem_addr and mem_wdata stable until mem_resp = 1.
  - ISSUE, on mem_resp: mem_write <= 0, write_count += 1, go to IDLE.
  - There is always one IDLE cycle between consecutive writes.
  - mem_resp is sampled only in ISSUE. It may arrive in the first cycle mem_write is high, giving a minimum 1-cycle write.
- Latency, entry pushed at edge N into an empty FIFO in IDLE:
  - Popped at edge N+1; mem_write is high from edge N+1.
  - With immediate mem_resp, throughput is 1 write per 2 cycles.
- done = (occupancy == 0) & (state == IDLE), combinational from registers.
  - done falls the cycle after a push into an empty idle block.
  - done rises the cycle after the last mem_resp or last skip pop.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- addr and data are taken verbatim from the FIFO entry; no width conversion.

Test Plan:
- Single write: COND_WRITE = 0; push addr 0x10, data 0xAA; mem_resp returned 3 cycles after mem_write rises -> mem_write high for exactly 3 cycles with addr 0x10 / data 0xAA stable throughout; write_count = 1; done returns to 1.
- Fill and backpressure: DEPTH = 4; valid_i held high for 6 entries, mem_resp held 0 -> ready_o drops after 4 accepted entries plus 1 popped into ISSUE (5 total); occupancy = 4; entries 6+ held upstream; releasing mem_resp drains all entries in push order.
- Conditional skip: COND_WRITE = 1; push flags 1,0,0,1 with addrs 0x0,0x8,0x10,0x18 -> memory sees only 0x0 and 0x18; skip_count = 2; write_count = 2; done = 1 at end.
- Immediate response: mem_resp tied to mem_write; push 8 entries back-to-back -> 8 writes completed, one every 2 cycles, addresses in push order; pointer wrap is exercised.
- Reset mid-write: 3 entries buffered and mem_write high, assert rst for 1 cycle -> next cycle mem_write = 0, occupancy = 0, counters = 0, done = 1; a late mem_resp is ignored.
- Counter saturation: CNT_WIDTH = 2; complete 5 writes -> write_count stops at 3.
